// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer for the IF/ID register: owns the PC, the imem request
// handshake and a 2-entry {pc4, ins} FIFO; redirects flush the FIFO and emit a NOP bubble.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4,
    output logic [31:0] ins,
    output logic        we
);

    // Handshake: a request stays asserted with a fixed address until imem_ack is seen
    // with imem_req=1; imem_rdata is taken in that same cycle. ack without req is ignored.
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] fifo_pc4_q [0:1];
    logic [31:0] fifo_pc4_d [0:1];
    logic [31:0] fifo_ins_q [0:1];
    logic [31:0] fifo_ins_d [0:1];

    logic ack_v;
    logic push;
    logic pop;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_pc4_d = fifo_pc4_q;
        fifo_ins_d = fifo_ins_q;

        imem_req  = 1'b0;
        we        = 1'b0;
        pc4       = 32'h0;
        ins       = 32'h0;
        ack_v     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        // In WAIT/DROP the address comes from addr_q so a redirect cannot move it.
        imem_addr = (state_q == S_RUN) ? pc_q : addr_q;

        if (!clrn) begin
            if (state_q == S_RUN) begin
                imem_req = (count_q < 2'd2) && !redirect;
                addr_d   = pc_q;
            end else begin
                imem_req = 1'b1;
            end

            ack_v = imem_req && imem_ack;
            push  = ack_v && ((state_q == S_RUN) || (state_q == S_WAIT && !redirect));
            we    = redirect || ((count_q != 2'd0) && !stall);
            pop   = we && !redirect;

            if (redirect) begin
                ins = NOP_INST;
                pc4 = 32'h0;
            end else if (count_q != 2'd0) begin
                pc4 = fifo_pc4_q[rd_ptr_q];
                ins = fifo_ins_q[rd_ptr_q];
            end

            case (state_q)
                S_RUN:   if (imem_req && !imem_ack) state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_ack)      state_d = S_RUN;
                    else if (redirect) state_d = S_DROP;
                end
                S_DROP:  if (imem_ack) state_d = S_RUN;
                default: state_d = S_RUN;
            endcase

            if (push) begin
                fifo_pc4_d[wr_ptr_q] = imem_addr + 32'd4;
                fifo_ins_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d             = ~wr_ptr_q;
                pc_d                 = imem_addr + 32'd4;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};

            if (redirect) begin
                pc_d     = target;
                count_d  = 2'd0;
                rd_ptr_d = 1'b0;
                wr_ptr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            fifo_pc4_q[0] <= 32'h0;
            fifo_pc4_q[1] <= 32'h0;
            fifo_ins_q[0] <= 32'h0;
            fifo_ins_q[1] <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_pc4_q <= fifo_pc4_d;
            fifo_ins_q <= fifo_ins_d;
        end
    end

endmodule
